hms_counter: RTL and testbench
==============================

# hms_counter

BCD time-of-day counter that produces the 24-bit `hms` vector (hour, minute, second) consumed by the hourly-chime stage and the display path. It advances on a one-cycle 1 Hz enable and supports direct loading and per-field manual adjustment. The `hour_pulse` output marks every top-of-hour rollover for downstream alarm and chime logic.

## Interface
- `CP` in 1: system clock; all state updates on the rising edge.
- `CR` in 1: synchronous active-high reset.
- `tick` in 1: 1 Hz count enable, high for exactly one `CP` cycle per second.
- `adj_en` in 1: adjust mode; while high, `tick` is ignored and time is frozen.
- `adj_sel` in 2: field to adjust.
  - 2'b00: seconds.
  - 2'b01: minutes.
  - 2'b10: hours.
  - 2'b11: no field; `adj_inc` is ignored.
- `adj_inc` in 1: one-cycle adjust strobe, acted on only while `adj_en` is high.
- `load` in 1: one-cycle strobe that loads `load_hms`.
- `load_hms` in 24: BCD value to load, laid out as [23:16] hour, [15:8] minute, [7:0] second.
- `hms` out 24: current time in packed BCD; each byte is {tens, units}.
- `hour_pulse` out 1: one-cycle pulse when the count rolls from xx:59:59 to (xx+1):00:00 via `tick`.
- `load_err` out 1: one-cycle pulse when a `load` is rejected because `load_hms` is invalid.

## Operation
- Priority order, evaluated on each `CP` edge: `CR` > `load` > adjust (`adj_en` && `adj_inc`) > count (`tick` && !`adj_en`) > hold.
- Reset (`CR`=1):
  - `hms` = 24'h000000.
  - `hour_pulse` = 0.
  - `load_err` = 0.
  - All other inputs are ignored in that cycle.
- Count. Each field is a BCD pair; the units digit carries into the tens digit at 9 -> 0.
  - Seconds: 00..59; 59 wraps to 00 and generates a minute carry.
  - Minutes: 00..59, advanced only by the minute carry; 59 wraps to 00 and generates an hour carry.
  - Hours: 00..23, advanced only by the hour carry; 23 wraps to 00.
  - `hour_pulse` = 1 in the cycle after the edge that applied the hour carry. This includes 23:59:59 -> 00:00:00.
- Adjust:
  - sec: `adj_inc` clears seconds to 00.
  - min: `adj_inc` increments minutes modulo 60.
  - hour: `adj_inc` increments hours modulo 24.
  - No carry propagates into other fields.
  - `hour_pulse` is never asserted by an adjust.
- Load:
  - `load_hms` is accepted only if every digit is <= 9, hour <= 8'h23, minute <= 8'h59 and second <= 8'h59.
  - Accepted: `hms` <= `load_hms` and `load_err` = 0.
  - Rejected: `hms` holds and `load_err` = 1 for one cycle.
  - `load` is honoured regardless of `adj_en`.
- A `tick` that coincides with a `load`, an adjust, or `adj_en`=1 is dropped, not deferred.
- `hour_pulse` and `load_err` are never high in the same cycle.
- Internal digit registers never hold a non-BCD value. The state is reachable only through reset, validated load, or the modulo arithmetic above.

## Timing
- All outputs are registered. Every change is visible one `CP` cycle after the qualifying edge, with no combinational input-to-output path.
- Latency is 1 cycle for each of the following:
  - `tick` -> `hms` update.
  - `load` -> `hms` update or `load_err`.
  - `adj_inc` -> `hms` update.
- `hour_pulse` rises on the same edge as the `hms` transition to mm:ss = 00:00, so downstream logic sees xx:00:00 and `hour_pulse` together.
- Back-to-back `tick` or `adj_inc` on consecutive cycles must each take effect; there is no minimum spacing.
- A reset asserted mid-operation discards any pending strobe in that cycle. Counting resumes on the first `tick` after `CR` falls.

## Test plan
- Reset:
  - Stimulus: assert `CR` with `tick`=1 and `load`=1 (`load_hms`=24'h123456).
  - Required: `hms`=24'h000000, `hour_pulse`=0 and `load_err`=0 the next cycle.
- Full-day rollover:
  - Stimulus: load 24'h235959, then one `tick`.
  - Required: `hms`=24'h000000 and `hour_pulse`=1 for exactly one cycle.
- Digit carry:
  - Stimulus: load 24'h095959, then `tick`; separately, load 24'h120009, then `tick`.
  - Required: 24'h100000 with `hour_pulse`=1; 24'h120010 with `hour_pulse`=0.
- Adjust isolation:
  - Stimulus: from 24'h225930, set `adj_en`=1 and `adj_sel`=01, then pulse `adj_inc`; also apply `tick` during `adj_en`.
  - Required: `hms`=24'h220030, no hour change, `tick` ignored.
  - Stimulus: with `adj_sel`=10, two `adj_inc` strobes.
  - Required: `hms`=24'h000030.
- Invalid load:
  - Stimulus: from 24'h010203, `load` with 24'h240000, then with 24'h005A00.
  - Required: `hms` stays 24'h010203 and `load_err` pulses once per attempt.
- Simultaneous events:
  - Stimulus: `load` of 24'h101010 in the same cycle as `tick` and `adj_inc`.
  - Required: `hms`=24'h101010, `hour_pulse`=0, and no extra increment on following cycles.

Source files
------------

// File: rtl/hms_counter.sv
// hms_counter: BCD hour/minute/second time-of-day counter with validated
// load, per-field manual adjust and a top-of-hour pulse. All outputs are
// registered; the next state is formed in one combinational block.
module hms_counter (
  input  logic        CP,
  input  logic        CR,
  input  logic        tick,
  input  logic        adj_en,
  input  logic [1:0]  adj_sel,
  input  logic        adj_inc,
  input  logic        load,
  input  logic [23:0] load_hms,
  output logic [23:0] hms,
  output logic        hour_pulse,
  output logic        load_err
);

  localparam logic [1:0] SEL_SEC  = 2'b00;
  localparam logic [1:0] SEL_MIN  = 2'b01;
  localparam logic [1:0] SEL_HOUR = 2'b10;

  localparam logic [7:0] MAX_MS   = 8'h59;
  localparam logic [7:0] MAX_HOUR = 8'h23;

  // Field registers, each one packed BCD byte {tens, units}.
  logic [7:0] sec_q,  sec_d;
  logic [7:0] min_q,  min_d;
  logic [7:0] hour_q, hour_d;
  logic       hour_pulse_q, hour_pulse_d;
  logic       load_err_q,   load_err_d;

  // Wrap flag and incremented value for each field.
  logic [8:0] sec_inc, min_inc, hour_inc;
  logic       load_ok;

  // Increment a BCD byte, wrapping to 00 at 'max'. Bit 8 flags the wrap.
  function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    logic [3:0] tens_p1;
    logic [3:0] units_p1;
    tens_p1  = v[7:4] + 4'd1;
    units_p1 = v[3:0] + 4'd1;
    if (v == max) begin
      bcd_inc = {1'b1, 8'h00};
    end else if (v[3:0] == 4'd9) begin
      bcd_inc = {1'b0, tens_p1, 4'd0};
    end else begin
      bcd_inc = {1'b0, v[7:4], units_p1};
    end
  endfunction

  // True when both digits are decimal and the byte does not exceed 'max'.
  function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] max);
    bcd_ok = (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
  endfunction

  // Per-field increments and load validation, shared by count, adjust and load.
  always_comb begin
    sec_inc  = bcd_inc(sec_q,  MAX_MS);
    min_inc  = bcd_inc(min_q,  MAX_MS);
    hour_inc = bcd_inc(hour_q, MAX_HOUR);
    load_ok  = bcd_ok(load_hms[23:16], MAX_HOUR) &&
               bcd_ok(load_hms[15:8],  MAX_MS)   &&
               bcd_ok(load_hms[7:0],   MAX_MS);
  end

  // Next-state selection: load beats adjust beats count; a losing tick is dropped.
  always_comb begin
    sec_d        = sec_q;
    min_d        = min_q;
    hour_d       = hour_q;
    hour_pulse_d = 1'b0;
    load_err_d   = 1'b0;
    if (load) begin
      if (load_ok) begin
        hour_d = load_hms[23:16];
        min_d  = load_hms[15:8];
        sec_d  = load_hms[7:0];
      end else begin
        load_err_d = 1'b1;
      end
    end else if (adj_en && adj_inc) begin
      // Adjust touches one field only; no carries ripple out.
      case (adj_sel)
        SEL_SEC:  sec_d  = 8'h00;
        SEL_MIN:  min_d  = min_inc[7:0];
        SEL_HOUR: hour_d = hour_inc[7:0];
        default:  ;
      endcase
    end else if (tick && !adj_en) begin
      sec_d = sec_inc[7:0];
      if (sec_inc[8]) begin
        min_d = min_inc[7:0];
        if (min_inc[8]) begin
          hour_d       = hour_inc[7:0];
          hour_pulse_d = 1'b1;
        end
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CP) begin
    if (CR) begin
      sec_q        <= 8'h00;
      min_q        <= 8'h00;
      hour_q       <= 8'h00;
      hour_pulse_q <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      sec_q        <= sec_d;
      min_q        <= min_d;
      hour_q       <= hour_d;
      hour_pulse_q <= hour_pulse_d;
      load_err_q   <= load_err_d;
    end
  end

  assign hms        = {hour_q, min_q, sec_q};
  assign hour_pulse = hour_pulse_q;
  assign load_err   = load_err_q;

endmodule

// File: tb/tb_hms_counter.sv
// Directed testbench for hms_counter: each task drives one scenario and
// compares {hms, hour_pulse, load_err} against hand-computed values.
module tb_hms_counter;

  logic        CP = 1'b0;
  logic        CR = 1'b0;
  logic        tick = 1'b0;
  logic        adj_en = 1'b0;
  logic [1:0]  adj_sel = 2'b00;
  logic        adj_inc = 1'b0;
  logic        load = 1'b0;
  logic [23:0] load_hms = 24'h0;
  logic [23:0] hms;
  logic        hour_pulse;
  logic        load_err;

  int checks = 0;
  int errors = 0;

  hms_counter dut (
    .CP(CP), .CR(CR), .tick(tick), .adj_en(adj_en), .adj_sel(adj_sel),
    .adj_inc(adj_inc), .load(load), .load_hms(load_hms),
    .hms(hms), .hour_pulse(hour_pulse), .load_err(load_err)
  );

  always #5 CP = ~CP;

  // Advance one clock edge and sample 1 time unit later.
  task automatic step();
    @(posedge CP);
    #1;
  endtask

  // Load a value and release the strobe (used for setup).
  task automatic do_load(input logic [23:0] v);
    load = 1'b1; load_hms = v;
    step();
    load = 1'b0;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic test_reset();
    CR = 1'b1; tick = 1'b1; load = 1'b1; load_hms = 24'h123456;
    step();
    CR = 1'b0; tick = 1'b0; load = 1'b0;
    checks++;
    if ({hms, hour_pulse, load_err} !== {24'h000000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset: hms=%h hp=%b le=%b expected 000000 0 0", hms, hour_pulse, load_err);
    end
    $display("reset -> hms=%h hp=%b le=%b", hms, hour_pulse, load_err);
  endtask

  task automatic test_full_day();
    do_load(24'h235959);
    checks++;
    if ({hms, hour_pulse, load_err} !== {24'h235959, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL load_235959: hms=%h hp=%b le=%b expected 235959 0 0", hms, hour_pulse, load_err);
    end
    do_tick();
    checks++;
    if ({hms, hour_pulse, load_err} !== {24'h000000, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL day_rollover: hms=%h hp=%b le=%b expected 000000 1 0", hms, hour_pulse, load_err);
    end
    $display("tick 235959 -> hms=%h hp=%b", hms, hour_pulse);
    step();
    checks++;
    if ({hms, hour_pulse, load_err} !== {24'h000000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL hour_pulse_width: hms=%h hp=%b le=%b expected 000000 0 0", hms, hour_pulse, load_err);
    end
  endtask

  task automatic test_digit_carry();
    do_load(24'h095959);
    do_tick();
    checks++;
    if ({hms, hour_pulse, load_err} !== {24'h100000, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL hour_digit_carry: hms=%h hp=%b le=%b expected 100000 1 0", hms, hour_pulse, load_err);
    end
    $display("tick 095959 -> hms=%h hp=%b", hms, hour_pulse);
    do_load(24'h120009);
    do_tick();
    checks++;
    if ({hms, hour_pulse, load_err} !== {24'h120010, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL sec_digit_carry: hms=%h hp=%b le=%b expected 120010 0 0", hms, hour_pulse, load_err);
    end
    $display("tick 120009 -> hms=%h hp=%b", hms, hour_pulse);
  endtask

  task automatic test_adjust();
    do_load(24'h225930);
    adj_en = 1'b1; adj_sel = 2'b01; adj_inc = 1'b1;
    step();
    adj_inc = 1'b0;
    checks++;
    if ({hms, hour_pulse, load_err} !== {24'h220030, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL adj_min_wrap: hms=%h hp=%b le=%b expected 220030 0 0", hms, hour_pulse, load_err);
    end
    $display("adj min 225930 -> hms=%h", hms);
    do_tick();
    checks++;
    if ({hms, hour_pulse, load_err} !== {24'h220030, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL tick_in_adjust: hms=%h hp=%b le=%b expected 220030 0 0", hms, hour_pulse, load_err);
    end
    adj_sel = 2'b10; adj_inc = 1'b1;
    step();
    checks++;
    if ({hms, hour_pulse, load_err} !== {24'h230030, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL adj_hour_1: hms=%h hp=%b le=%b expected 230030 0 0", hms, hour_pulse, load_err);
    end
    step();
    adj_inc = 1'b0;
    checks++;
    if ({hms, hour_pulse, load_err} !== {24'h000030, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL adj_hour_wrap: hms=%h hp=%b le=%b expected 000030 0 0", hms, hour_pulse, load_err);
    end
    $display("adj hour x2 -> hms=%h hp=%b", hms, hour_pulse);
    adj_sel = 2'b00; adj_inc = 1'b1;
    step();
    adj_inc = 1'b0;
    checks++;
    if (hms !== 24'h000000) begin
      errors++;
      $display("FAIL adj_sec_clear: hms=%h expected 000000", hms);
    end
    do_load(24'h134512);
    adj_sel = 2'b11; adj_inc = 1'b1;
    step();
    adj_inc = 1'b0; adj_en = 1'b0;
    checks++;
    if (hms !== 24'h134512) begin
      errors++;
      $display("FAIL adj_sel_none: hms=%h expected 134512", hms);
    end
  endtask

  task automatic test_invalid_load();
    do_load(24'h010203);
    do_load(24'h240000);
    checks++;
    if ({hms, hour_pulse, load_err} !== {24'h010203, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL bad_hour_load: hms=%h hp=%b le=%b expected 010203 0 1", hms, hour_pulse, load_err);
    end
    $display("load 240000 -> hms=%h le=%b", hms, load_err);
    step();
    checks++;
    if (load_err !== 1'b0) begin
      errors++;
      $display("FAIL load_err_width: le=%b expected 0", load_err);
    end
    do_load(24'h005A00);
    checks++;
    if ({hms, hour_pulse, load_err} !== {24'h010203, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL bad_digit_load: hms=%h hp=%b le=%b expected 010203 0 1", hms, hour_pulse, load_err);
    end
    $display("load 005A00 -> hms=%h le=%b", hms, load_err);
    do_load(24'h000060);
    checks++;
    if ({hms, load_err} !== {24'h010203, 1'b1}) begin
      errors++;
      $display("FAIL bad_sec_load: hms=%h le=%b expected 010203 1", hms, load_err);
    end
  endtask

  task automatic test_simultaneous();
    do_load(24'h000030);
    load = 1'b1; load_hms = 24'h101010; tick = 1'b1;
    adj_en = 1'b1; adj_sel = 2'b01; adj_inc = 1'b1;
    step();
    load = 1'b0; tick = 1'b0; adj_en = 1'b0; adj_inc = 1'b0;
    checks++;
    if ({hms, hour_pulse, load_err} !== {24'h101010, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL simultaneous: hms=%h hp=%b le=%b expected 101010 0 0", hms, hour_pulse, load_err);
    end
    step();
    step();
    checks++;
    if (hms !== 24'h101010) begin
      errors++;
      $display("FAIL no_deferred_tick: hms=%h expected 101010", hms);
    end
    $display("load+tick+adj -> hms=%h", hms);
  endtask

  task automatic test_back_to_back();
    do_load(24'h005958);
    tick = 1'b1;
    step();
    checks++;
    if ({hms, hour_pulse} !== {24'h005959, 1'b0}) begin
      errors++;
      $display("FAIL b2b_tick_1: hms=%h hp=%b expected 005959 0", hms, hour_pulse);
    end
    step();
    tick = 1'b0;
    checks++;
    if ({hms, hour_pulse} !== {24'h010000, 1'b1}) begin
      errors++;
      $display("FAIL b2b_tick_2: hms=%h hp=%b expected 010000 1", hms, hour_pulse);
    end
    $display("b2b ticks 005958 -> hms=%h hp=%b", hms, hour_pulse);
  endtask

  task automatic test_reset_mid();
    do_load(24'h101010);
    CR = 1'b1; tick = 1'b1;
    step();
    CR = 1'b0;
    checks++;
    if (hms !== 24'h000000) begin
      errors++;
      $display("FAIL reset_mid: hms=%h expected 000000", hms);
    end
    step();
    tick = 1'b0;
    checks++;
    if (hms !== 24'h000001) begin
      errors++;
      $display("FAIL resume_after_reset: hms=%h expected 000001", hms);
    end
    $display("reset mid + tick -> hms=%h", hms);
  endtask

  initial begin
    test_reset();
    test_full_day();
    test_digit_carry();
    test_adjust();
    test_invalid_load();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
